// File: rtl/spi_controller_if.sv
// Command/status handshake plus SPI pins between a requester and spi_controller.
// master = requester side (also models the peripheral's cipo); slave = the controller.
interface spi_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, cipo,
    input  cmd_ready, busy, done, rx_data, sclk, copi, ncs
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, cipo,
    output cmd_ready, busy, done, rx_data, sclk, copi, ncs
  );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 master: one 16-bit {rw, addr[6:0], data[7:0]} frame per accepted command.
// Latency 34*CLK_DIV cycles accept-to-done; cmd_ready low while busy, cmd_valid ignored then.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [3:0]     fall_cnt, fall_cnt_d;
  logic [15:0]    frame, frame_d;
  logic [7:0]     rx_sh, rx_sh_d;
  logic [7:0]     rx_data, rx_data_d;
  logic           sclk, sclk_d;
  logic           copi, copi_d;
  logic           ncs, ncs_d;
  logic           done, done_d;
  logic           cnt_end;

  assign cnt_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      fall_cnt <= '0;
      frame    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      copi     <= 1'b0;
      ncs      <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      fall_cnt <= fall_cnt_d;
      frame    <= frame_d;
      rx_sh    <= rx_sh_d;
      rx_data  <= rx_data_d;
      sclk     <= sclk_d;
      copi     <= copi_d;
      ncs      <= ncs_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    fall_cnt_d = fall_cnt;
    frame_d    = frame;
    rx_sh_d    = rx_sh;
    rx_data_d  = rx_data;
    sclk_d     = sclk;
    copi_d     = copi;
    ncs_d      = ncs;
    done_d     = 1'b0;

    if (state != IDLE) begin
      cnt_d = cnt_end ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          frame_d    = {bus.cmd_write, bus.cmd_addr, bus.cmd_data};
          copi_d     = bus.cmd_write;
          ncs_d      = 1'b0;
          cnt_d      = '0;
          fall_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_end) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh[6:0], bus.cipo};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_end) begin
          if (!sclk) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh[6:0], bus.cipo};
          end else begin
            sclk_d = 1'b0;
            // frame shifts left each fall so the next bit to send is always at [14]
            if (fall_cnt == 4'd15) begin
              state_d = HOLD;
            end else begin
              copi_d     = frame[14];
              frame_d    = {frame[14:0], 1'b0};
              fall_cnt_d = fall_cnt + 4'd1;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_end) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_end) begin
          rx_data_d = rx_sh;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
  assign bus.rx_data   = rx_data;
  assign bus.sclk      = sclk;
  assign bus.copi      = copi;
  assign bus.ncs       = ncs;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller at CLK_DIV=4 with a pin-level SPI monitor and CIPO model.
module tb_spi_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_controller_if bus();

  spi_controller #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  logic        p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1;
  logic [7:0]  p_rx = 8'h00;
  logic [15:0] cap = 16'h0;
  logic [15:0] cipo_word = 16'h0;
  int rises = 0, edges = 0, gap_bad = 0, copi_bad = 0, rx_bad = 0, done_cnt = 0;
  int done_cyc = 0, ncs_fall_cyc = 0, ncs_rise_cyc = 0, first_rise_cyc = 0;
  int last_fall_cyc = 0, last_rise_cyc = -100, last_edge_cyc = 0, copi_chg_cyc = -100;
  int ncs_gap = 0;
  logic [15:0] frame_log[$];
  int          rise_log[$];

  always @(negedge clk) begin
    if (p_ncs && !bus.ncs) begin
      ncs_fall_cyc = cyc;
      ncs_gap = cyc - ncs_rise_cyc;
      rises = 0;
      edges = 0;
      cap = 16'h0;
    end
    if (!p_ncs && bus.ncs) begin
      ncs_rise_cyc = cyc;
      frame_log.push_back(cap);
      rise_log.push_back(rises);
    end
    if (bus.sclk != p_sclk) begin
      if (edges > 0 && (cyc - last_edge_cyc) != 4) gap_bad++;
      last_edge_cyc = cyc;
      edges++;
      if (bus.sclk) begin
        if (!bus.ncs) begin
          rises++;
          cap = {cap[14:0], bus.copi};
          if (rises == 1) first_rise_cyc = cyc;
        end
        if ((cyc - copi_chg_cyc) <= 1) copi_bad++;
        last_rise_cyc = cyc;
      end else begin
        last_fall_cyc = cyc;
      end
    end
    if (bus.copi != p_copi) begin
      if ((cyc - last_rise_cyc) <= 1) copi_bad++;
      copi_chg_cyc = cyc;
    end
    if (bus.rx_data != p_rx && !bus.done) rx_bad++;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_sclk = bus.sclk;
    p_copi = bus.copi;
    p_ncs  = bus.ncs;
    p_rx   = bus.rx_data;
    // peripheral shifts out on falls; bit for rise k is cipo_word[16-k]
    bus.cipo = (!bus.ncs && rises < 16) ? cipo_word[15 - rises] : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats();
    gap_bad = 0; copi_bad = 0; rx_bad = 0; done_cnt = 0;
    frame_log.delete();
    rise_log.delete();
  endtask

  task automatic start_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_cmd_ready: cmd_ready=%b required 1 within 400 cycles", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 7'($urandom);
    bus.cmd_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout: done=%b required 1 within 400 cycles", name, bus.done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_data = '0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.ncs !== 1'b1) begin failures++; $display("FAIL reset_ncs: got %b want 1", bus.ncs); end
    checks++; if (bus.sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b want 0", bus.sclk); end
    checks++; if (bus.copi !== 1'b0) begin failures++; $display("FAIL reset_copi: got %b want 0", bus.copi); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_write();
    cipo_word = 16'h0000;
    clear_stats();
    start_cmd(1'b1, 7'h00, 8'hF0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL write_ready: got %b want 0", bus.cmd_ready); end
    wait_done("write");
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL write_done_width: got %b want 0", bus.done); end
    checks++; if (frame_log.size() != 1 || frame_log[0] !== 16'h80F0) begin
      failures++; $display("FAIL write_frame: got %h (frames=%0d) want 80f0", cap, frame_log.size()); end
    checks++; if (rise_log.size() != 1 || rise_log[0] != 16) begin
      failures++; $display("FAIL write_rises: got %0d want 16", rises); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL write_done_count: got %0d want 1", done_cnt); end
    checks++; if ((done_cyc - ncs_fall_cyc) != 136) begin
      failures++; $display("FAIL write_latency: got %0d want 136", done_cyc - ncs_fall_cyc); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL write_rx_data: got %h want 00", bus.rx_data); end
  endtask

  task automatic test_edge_spacing();
    cipo_word = 16'h0000;
    clear_stats();
    start_cmd(1'b0, 7'h7F, 8'h55);
    wait_done("edges");
    checks++; if (gap_bad != 0) begin failures++; $display("FAIL edges_spacing: bad gaps %0d want 0", gap_bad); end
    checks++; if (edges != 32) begin failures++; $display("FAIL edges_count: got %0d want 32", edges); end
    checks++; if ((first_rise_cyc - ncs_fall_cyc) != 4) begin
      failures++; $display("FAIL edges_lead: got %0d want 4", first_rise_cyc - ncs_fall_cyc); end
    checks++; if ((ncs_rise_cyc - last_fall_cyc) != 4) begin
      failures++; $display("FAIL edges_trail: got %0d want 4", ncs_rise_cyc - last_fall_cyc); end
    checks++; if (copi_bad != 0) begin failures++; $display("FAIL edges_copi_stable: violations %0d want 0", copi_bad); end
    checks++; if (frame_log.size() != 1 || frame_log[0] !== 16'h7F55) begin
      failures++; $display("FAIL edges_frame: got %h want 7f55", cap); end
  endtask

  task automatic test_back_to_back();
    bit seen_high = 0;
    bit second = 0;
    cipo_word = 16'h0000;
    clear_stats();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 7'h12; bus.cmd_data = 8'h34;
    @(posedge clk);
    #1;
    bus.cmd_write = 1'b0; bus.cmd_addr = 7'h56; bus.cmd_data = 8'h78;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.ncs === 1'b1) seen_high = 1;
      else if (seen_high && bus.ncs === 1'b0) begin second = 1; break; end
    end
    bus.cmd_valid = 1'b0;
    checks++; if (!second) begin failures++; $display("FAIL b2b_second_accept: ncs=%b, second frame not started", bus.ncs); end
    wait_done("b2b");
    checks++; if (frame_log.size() != 2) begin failures++; $display("FAIL b2b_frames: got %0d want 2", frame_log.size()); end
    checks++; if (frame_log.size() < 1 || frame_log[0] !== 16'h9234) begin
      failures++; $display("FAIL b2b_frame_a: got %h want 9234", frame_log.size() > 0 ? frame_log[0] : 16'h0); end
    checks++; if (frame_log.size() < 2 || frame_log[1] !== 16'h5678) begin
      failures++; $display("FAIL b2b_frame_b: got %h want 5678", frame_log.size() > 1 ? frame_log[1] : 16'h0); end
    checks++; if (ncs_gap != 5) begin failures++; $display("FAIL b2b_ncs_gap: got %0d want 5", ncs_gap); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
  endtask

  task automatic test_readback();
    cipo_word = 16'hFFA5;
    clear_stats();
    start_cmd(1'b0, 7'h10, 8'h00);
    wait_done("readback");
    checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL readback_rx_data: got %h want a5", bus.rx_data); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus.rx_data !== 8'hA5) begin failures++; $display("FAIL readback_hold: got %h want a5", bus.rx_data); end
    checks++; if (rx_bad != 0) begin failures++; $display("FAIL readback_rx_glitch: changes %0d want 0", rx_bad); end
  endtask

  task automatic test_reset_midframe();
    bit ok = 0;
    cipo_word = 16'hFFFF;
    start_cmd(1'b1, 7'h55, 8'hAA);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rises >= 7) begin ok = 1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL midrst_rise7: rises=%0d want 7", rises); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ncs !== 1'b1) begin failures++; $display("FAIL midrst_ncs: got %b want 1", bus.ncs); end
    checks++; if (bus.sclk !== 1'b0) begin failures++; $display("FAIL midrst_sclk: got %b want 0", bus.sclk); end
    checks++; if (bus.copi !== 1'b0) begin failures++; $display("FAIL midrst_copi: got %b want 0", bus.copi); end
    checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data: got %h want 00", bus.rx_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cipo_word = 16'h00C3;
    clear_stats();
    start_cmd(1'b1, 7'h02, 8'h3C);
    wait_done("midrst");
    checks++; if (frame_log.size() != 1 || frame_log[0] !== 16'h823C) begin
      failures++; $display("FAIL midrst_frame: got %h want 823c", cap); end
    checks++; if (rise_log.size() != 1 || rise_log[0] != 16) begin
      failures++; $display("FAIL midrst_rises: got %0d want 16", rises); end
    checks++; if (bus.rx_data !== 8'hC3) begin failures++; $display("FAIL midrst_rx_data: got %h want c3", bus.rx_data); end
    checks++; if (gap_bad != 0 || done_cnt != 1) begin
      failures++; $display("FAIL midrst_clean: gaps=%0d done=%0d want 0/1", gap_bad, done_cnt); end
  endtask

  initial begin
    bus.cipo = 1'b0;
    test_reset();
    test_single_write();
    test_edge_spacing();
    test_back_to_back();
    test_readback();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
